// File: rtl/dmem_pkg.sv
// Shared types and helpers for the handshaked byte/word data memory.
// Optional range checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
package dmem_pkg;

    localparam logic SIZE_BYTE = 1'b0;
    localparam logic SIZE_WORD = 1'b1;

    localparam int MAX_BPW = 64;

    typedef enum logic {
        IDLE,
        SPLIT
    } state_t;

    // Bit i of the result enables lane i, where lane 0 is the most significant byte of a row.
    function automatic logic [MAX_BPW-1:0] laneStrobe(input int bpw, input int offset,
                                                      input logic size, input logic secondBeat);
        logic [MAX_BPW-1:0] strobe;
        strobe = '0;
        for (int i = 0; i < MAX_BPW; i++) begin
            if (i < bpw) begin
                if (size == SIZE_BYTE)
                    strobe[i] = (i == offset);
                else if (secondBeat)
                    strobe[i] = (i < offset);
                else
                    strobe[i] = (i >= offset);
            end
        end
        return strobe;
    endfunction

endpackage

// File: rtl/data_memory_hs_if.sv
// Request/response bundle between the load/store stage and the data memory.
// Used by data_memory_hs (slave side) and its requester (master side).
interface data_memory_hs_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16
);
    logic              ReqValid;
    logic              ReqReady;
    logic              ReqWrite;
    logic              ReqSize;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] WriteData;
    logic              RespValid;
    logic [DATA_W-1:0] ReadData;
    logic              Error;

    modport master (
        output ReqValid, ReqWrite, ReqSize, Address, WriteData,
        input  ReqReady, RespValid, ReadData, Error
    );

    modport slave (
        input  ReqValid, ReqWrite, ReqSize, Address, WriteData,
        output ReqReady, RespValid, ReadData, Error
    );
endinterface

// File: rtl/dmem_row_ram.sv
// Row storage for the data memory: combinational read, clocked write with
// per-byte strobes (strobe bit i selects lane i, lane 0 being the MSB byte).
module dmem_row_ram #(
    parameter int DATA_W = 16,
    parameter int ROWS   = 64
) (
    input  logic                    Clock,
    input  logic                    i_we,
    input  logic [$clog2(ROWS)-1:0] i_row,
    input  logic [DATA_W/8-1:0]     i_strobe,
    input  logic [DATA_W-1:0]       i_wdata,
    output logic [DATA_W-1:0]       o_rdata
);
    localparam int BPW = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [ROWS];

    always_ff @(posedge Clock) begin
        if (i_we) begin
            for (int i = 0; i < BPW; i++) begin
                if (i_strobe[i])
                    r_mem[i_row][DATA_W-1-8*i -: 8] <= i_wdata[DATA_W-1-8*i -: 8];
            end
        end
    end

    assign o_rdata = r_mem[i_row];

endmodule

// File: rtl/data_memory_hs.sv
// Big-endian byte-addressed data memory with valid/ready requests and a registered response.
// Misaligned words take two row beats; DMEM_BOUNDS_CHECK_EN enables range errors instead of wrap.
module data_memory_hs
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 16
) (
    input logic              Clock,
    input logic              Reset_n,
    data_memory_hs_if.slave  bus
);
    localparam int BPW    = DATA_W / 8;
    localparam int ROWS   = DEPTH / BPW;
    localparam int ROW_W  = $clog2(ROWS);
    localparam int OFF_W  = $clog2(BPW);
    localparam int MEM_AW = $clog2(DEPTH);

    state_t            r_state;
    state_t            w_stateNext;
    logic              r_respValid;
    logic              r_error;
    logic [DATA_W-1:0] r_readData;

    logic [ROW_W-1:0]  r_row;
    logic [OFF_W-1:0]  r_off;
    logic              r_write;
    logic              r_err;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_beat1;

    logic [ROW_W-1:0]  w_reqRow;
    logic [OFF_W-1:0]  w_reqOff;
    logic              w_accept;
    logic              w_misaligned;
    logic              w_outOfRange;
    logic              w_unusedAddrHigh;
    logic [DATA_W-1:0] w_wordIn;
    logic [DATA_W-1:0] w_beat1Next;
    int                w_laneShift;
    int                w_splitShift;

    logic              w_ramWe;
    logic [ROW_W-1:0]  w_ramRow;
    logic [BPW-1:0]    w_ramStrobe;
    logic [DATA_W-1:0] w_ramWdata;
    logic [DATA_W-1:0] w_ramRdata;

    logic              w_respValidNext;
    logic              w_errorNext;
    logic [DATA_W-1:0] w_readDataNext;

    assign bus.ReqReady = (r_state == IDLE) && Reset_n;
    assign w_accept     = bus.ReqValid && bus.ReqReady;

    // Address bits above the memory size are dropped, so rows wrap modulo DEPTH.
    assign w_reqRow         = bus.Address[MEM_AW-1:OFF_W];
    assign w_reqOff         = bus.Address[OFF_W-1:0];
    assign w_unusedAddrHigh = ^bus.Address[ADDR_W-1:MEM_AW];
    assign w_misaligned     = (bus.ReqSize == SIZE_WORD) && (w_reqOff != '0);

`ifdef DMEM_BOUNDS_CHECK_EN
    logic [ADDR_W:0] w_lastByte;
    assign w_lastByte   = {1'b0, bus.Address}
                        + ((bus.ReqSize == SIZE_WORD) ? (ADDR_W+1)'(BPW - 1) : '0);
    assign w_outOfRange = (w_lastByte >= (ADDR_W+1)'(DEPTH));
`else
    assign w_outOfRange = 1'b0;
`endif

    // A byte write is placed in the top lane so both sizes shift into position the same way.
    assign w_wordIn     = (bus.ReqSize == SIZE_WORD) ? bus.WriteData
                                                     : {bus.WriteData[7:0], {(DATA_W-8){1'b0}}};
    assign w_laneShift  = 8 * int'(w_reqOff);
    assign w_splitShift = DATA_W - 8 * int'(r_off);
    assign w_beat1Next  = w_ramRdata << w_laneShift;

    dmem_row_ram #(
        .DATA_W (DATA_W),
        .ROWS   (ROWS)
    ) u_rowRam (
        .Clock    (Clock),
        .i_we     (w_ramWe),
        .i_row    (w_ramRow),
        .i_strobe (w_ramStrobe),
        .i_wdata  (w_ramWdata),
        .o_rdata  (w_ramRdata)
    );

    always_comb begin
        w_stateNext     = r_state;
        w_ramWe         = 1'b0;
        w_ramRow        = w_reqRow;
        w_ramStrobe     = '0;
        w_ramWdata      = '0;
        w_respValidNext = 1'b0;
        w_errorNext     = 1'b0;
        w_readDataNext  = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_ramWe     = bus.ReqWrite && !w_outOfRange;
                    w_ramStrobe = BPW'(laneStrobe(BPW, int'(w_reqOff), bus.ReqSize, 1'b0));
                    w_ramWdata  = w_wordIn >> w_laneShift;
                    if (w_misaligned) begin
                        w_stateNext = SPLIT;
                    end else begin
                        w_respValidNext = 1'b1;
                        w_errorNext     = w_outOfRange;
                        if (!bus.ReqWrite && !w_outOfRange)
                            w_readDataNext = (bus.ReqSize == SIZE_WORD)
                                           ? w_ramRdata
                                           : (w_ramRdata << w_laneShift) >> (DATA_W - 8);
                    end
                end
            end
            SPLIT: begin
                // Second beat covers lanes 0..offset-1 of the following row.
                w_ramRow        = r_row + ROW_W'(1);
                w_ramWe         = r_write && !r_err;
                w_ramStrobe     = BPW'(laneStrobe(BPW, int'(r_off), SIZE_WORD, 1'b1));
                w_ramWdata      = r_wdata << w_splitShift;
                w_respValidNext = 1'b1;
                w_errorNext     = r_err;
                if (!r_write && !r_err)
                    w_readDataNext = r_beat1 | (w_ramRdata >> w_splitShift);
                w_stateNext     = IDLE;
            end
            default: w_stateNext = IDLE;
        endcase
        if (!Reset_n)
            w_ramWe = 1'b0;
    end

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_respValid <= 1'b0;
            r_readData  <= '0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_respValid <= w_respValidNext;
            r_readData  <= w_readDataNext;
            r_error     <= w_errorNext;
        end
    end

    always_ff @(posedge Clock) begin
        if (w_accept && w_misaligned) begin
            r_row   <= w_reqRow;
            r_off   <= w_reqOff;
            r_write <= bus.ReqWrite;
            r_wdata <= bus.WriteData;
            r_beat1 <= w_beat1Next;
            r_err   <= w_outOfRange;
        end
    end

    assign bus.RespValid = r_respValid;
    assign bus.ReadData  = r_readData;
    assign bus.Error     = r_error;

endmodule

// File: tb/tb_data_memory_hs.sv
// Self-checking bench for data_memory_hs: directed cases plus randomized traffic
// checked against a byte-array reference model (honours DMEM_BOUNDS_CHECK_EN).
module tb_data_memory_hs;
    import dmem_pkg::*;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 128;
    localparam int ADDR_W = 16;
    localparam int BPW    = DATA_W / 8;

    logic clk = 1'b0;
    logic Reset_n;

    always #5 clk = ~clk;

    data_memory_hs_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_memory_hs #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .Clock   (clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int nVectors     = 0;
    int nMiscompares = 0;

    // Reference memory: one entry per byte address.
    logic [7:0] m [DEPTH];

    // Applies one request to the model; returns the expected ReadData and Error.
    function automatic logic [DATA_W-1:0] modelAccess(input logic w, input logic s,
                                                      input logic [ADDR_W-1:0] a,
                                                      input logic [DATA_W-1:0] wd,
                                                      output logic err);
        int n;
        logic [DATA_W-1:0] rd;
        n   = s ? BPW : 1;
        rd  = '0;
        err = 1'b0;
`ifdef DMEM_BOUNDS_CHECK_EN
        if (int'(a) + n - 1 >= DEPTH) err = 1'b1;
`endif
        if (err) return '0;
        for (int i = 0; i < n; i++) begin
            int idx;
            idx = (int'(a) + i) % DEPTH;
            if (w) m[idx] = s ? wd[DATA_W-1-8*i -: 8] : wd[7:0];
            else   rd = (rd << 8) | DATA_W'(m[idx]);
        end
        return w ? '0 : rd;
    endfunction

    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] obs,
                               input logic [DATA_W-1:0] exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        nVectors++;
        assert (obs === exp) else begin
            nMiscompares++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    // One isolated request: checks handshake, response latency and response payload.
    task automatic applyStimulus(input logic w, input logic s, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] wd, output logic [DATA_W-1:0] rdObs);
        logic              expErr;
        logic [DATA_W-1:0] expRd;
        bit                split;
        split = s && ((int'(a) % BPW) != 0);
        @(negedge clk);
        checkBit("resp_idle", bus.RespValid, 1'b0);
        checkBit("ready_idle", bus.ReqReady, 1'b1);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = w;
        bus.ReqSize   = s;
        bus.Address   = a;
        bus.WriteData = wd;
        expRd = modelAccess(w, s, a, wd, expErr);
        @(negedge clk);
        bus.ReqValid = 1'b0;
        if (split) begin
            checkBit("ready_split", bus.ReqReady, 1'b0);
            checkBit("resp_early", bus.RespValid, 1'b0);
            @(negedge clk);
        end
        checkBit("resp_valid", bus.RespValid, 1'b1);
        checkOutput("resp_data", bus.ReadData, expRd);
        checkBit("resp_error", bus.Error, expErr);
        rdObs = bus.ReadData;
    endtask

    initial begin
        logic [DATA_W-1:0] rd;
        logic [DATA_W-1:0] expQ [4];
        logic [ADDR_W-1:0] addrQ [4];
        logic              errQ [4];
        logic [7:0]        old6, old7F, old00, old32;

        Reset_n       = 1'b0;
        bus.ReqValid  = 1'b0;
        bus.ReqWrite  = 1'b0;
        bus.ReqSize   = SIZE_BYTE;
        bus.Address   = '0;
        bus.WriteData = '0;

        repeat (3) @(negedge clk);
        checkBit("reset_respvalid", bus.RespValid, 1'b0);
        checkOutput("reset_readdata", bus.ReadData, '0);
        checkBit("reset_error", bus.Error, 1'b0);
        Reset_n = 1'b1;
        #1;
        checkBit("ready_after_reset", bus.ReqReady, 1'b1);

        // Fill every row with known random data so the model matches the array.
        for (int a = 0; a < DEPTH; a += BPW)
            applyStimulus(1'b1, SIZE_WORD, ADDR_W'(a), DATA_W'($urandom), rd);

        // Aligned word write and reads.
        applyStimulus(1'b1, SIZE_WORD, 16'h0010, 16'h1234, rd);
        applyStimulus(1'b0, SIZE_WORD, 16'h0010, 16'h0000, rd);
        checkOutput("word_rd_10", rd, 16'h1234);
        applyStimulus(1'b0, SIZE_BYTE, 16'h0010, 16'h0000, rd);
        checkOutput("byte_rd_10", rd, 16'h0012);
        applyStimulus(1'b0, SIZE_BYTE, 16'h0011, 16'h0000, rd);
        checkOutput("byte_rd_11", rd, 16'h0034);

        // Misaligned word write and read.
        applyStimulus(1'b1, SIZE_WORD, 16'h0021, 16'hABCD, rd);
        applyStimulus(1'b0, SIZE_BYTE, 16'h0021, 16'h0000, rd);
        checkOutput("byte_rd_21", rd, 16'h00AB);
        applyStimulus(1'b0, SIZE_BYTE, 16'h0022, 16'h0000, rd);
        checkOutput("byte_rd_22", rd, 16'h00CD);
        applyStimulus(1'b0, SIZE_WORD, 16'h0021, 16'h0000, rd);
        checkOutput("word_rd_21", rd, 16'hABCD);

        // Byte write only touches its own lane.
        old6 = m[6];
        applyStimulus(1'b1, SIZE_BYTE, 16'h0007, 16'hFF5A, rd);
        applyStimulus(1'b0, SIZE_BYTE, 16'h0006, 16'h0000, rd);
        checkOutput("byte_rd_06", rd, {8'h00, old6});
        applyStimulus(1'b0, SIZE_WORD, 16'h0006, 16'h0000, rd);
        checkOutput("word_rd_06", rd, {old6, 8'h5A});

        // Word straddling the top of memory.
        old7F = m[7'h7F];
        old00 = m[0];
        applyStimulus(1'b1, SIZE_WORD, 16'h007F, 16'hBEEF, rd);
        applyStimulus(1'b0, SIZE_BYTE, 16'h007F, 16'h0000, rd);
`ifdef DMEM_BOUNDS_CHECK_EN
        checkOutput("edge_rd_7F", rd, {8'h00, old7F});
`else
        checkOutput("edge_rd_7F", rd, 16'h00BE);
`endif
        applyStimulus(1'b0, SIZE_BYTE, 16'h0000, 16'h0000, rd);
`ifdef DMEM_BOUNDS_CHECK_EN
        checkOutput("edge_rd_00", rd, {8'h00, old00});
`else
        checkOutput("edge_rd_00", rd, 16'h00EF);
`endif

        // Four back-to-back aligned reads.
        addrQ[0] = 16'h0010; addrQ[1] = 16'h0020; addrQ[2] = 16'h0040; addrQ[3] = 16'h007E;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                checkBit("b2b_valid", bus.RespValid, 1'b1);
                checkOutput("b2b_data", bus.ReadData, expQ[k-1]);
            end
            bus.ReqValid  = 1'b1;
            bus.ReqWrite  = 1'b0;
            bus.ReqSize   = SIZE_WORD;
            bus.Address   = addrQ[k];
            bus.WriteData = '0;
            expQ[k] = modelAccess(1'b0, SIZE_WORD, addrQ[k], '0, errQ[k]);
            #1;
            checkBit("b2b_ready", bus.ReqReady, 1'b1);
            @(negedge clk);
        end
        bus.ReqValid = 1'b0;
        checkBit("b2b_valid", bus.RespValid, 1'b1);
        checkOutput("b2b_data", bus.ReadData, expQ[3]);
        @(negedge clk);
        checkBit("b2b_pulse_end", bus.RespValid, 1'b0);

        // Reset while the second beat of a misaligned write is pending.
        old32 = m[8'h32];
        @(negedge clk);
        bus.ReqValid  = 1'b1;
        bus.ReqWrite  = 1'b1;
        bus.ReqSize   = SIZE_WORD;
        bus.Address   = 16'h0031;
        bus.WriteData = 16'h1122;
        @(negedge clk);
        bus.ReqValid = 1'b0;
        checkBit("rst_split_ready", bus.ReqReady, 1'b0);
        Reset_n = 1'b0;
        m[8'h31] = 8'h11;
        @(negedge clk);
        checkBit("rst_split_noresp", bus.RespValid, 1'b0);
        Reset_n = 1'b1;
        #1;
        checkBit("rst_split_ready_after", bus.ReqReady, 1'b1);
        @(negedge clk);
        checkBit("rst_split_noresp_after", bus.RespValid, 1'b0);
        applyStimulus(1'b0, SIZE_BYTE, 16'h0031, 16'h0000, rd);
        checkOutput("rst_rd_31", rd, 16'h0011);
        applyStimulus(1'b0, SIZE_BYTE, 16'h0032, 16'h0000, rd);
        checkOutput("rst_rd_32", rd, {8'h00, old32});

        // Randomized traffic, occasionally with address bits above the memory size.
        for (int n = 0; n < 150; n++) begin
            logic              w, s;
            logic [ADDR_W-1:0] a;
            w = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom)
                                            : ADDR_W'($urandom_range(0, DEPTH - 1));
            applyStimulus(w, s, a, DATA_W'($urandom), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule

// File: doc/data_memory_hs.md
# data_memory_hs

Parametrised, byte-addressed, big-endian data memory with a valid/ready request port and a registered response. It is the next-generation data memory for the CPU datapath. It supports byte and word accesses, and a misaligned word access is split internally into two row accesses. It sits between the load/store stage and the data-memory contents file, replacing the fixed 16-bit, 128-byte memory.

## Interface
- DATA_W, 16, word width in bits; multiple of 8, at least 16
- DEPTH, 128, memory size in bytes; multiple of DATA_W/8, power of two
- ADDR_W, 16, address width in bits
- Clock  in  1  rising-edge clock
- Reset_n  in  1  reset, synchronous, active-low
- ReqValid  in  1  request present
- ReqReady  out  1  request can be accepted; high only in state IDLE
- ReqWrite  in  1  1 = write, 0 = read
- ReqSize  in  1  0 = byte, 1 = word
- Address  in  ADDR_W  byte address of the first (most significant) byte
- WriteData  in  DATA_W  write data; a byte write uses WriteData[7:0]
- RespValid  out  1  single-cycle pulse; one per accepted request, for reads and writes
- ReadData  out  DATA_W  read result, valid while RespValid is high; 0 for writes
- Error  out  1  range violation, valid with RespValid; tied 0 without DMEM_BOUNDS_CHECK_EN

## Operation
- BPW = DATA_W/8. Storage is DEPTH/BPW rows of DATA_W bits.
- For byte address a: row = (a mod DEPTH)/BPW, lane offset o = a mod BPW. Lane 0 is the most significant byte.
- Big-endian ordering: byte a+i holds word bits [DATA_W-1-8i -: 8].
- Byte read: ReadData = {zeros, byte}.
- Byte write: only the addressed lane is written. All other bytes are unchanged.
- Aligned word (o = 0): one row access.
- Misaligned word (o ≠ 0):
  - Beat 1 accesses bytes o..BPW-1 of the row.
  - Beat 2 accesses bytes 0..o-1 of row+1.
  - Write lanes are byte-strobed.
- Row wrap without the macro: row DEPTH/BPW-1 plus 1 wraps to row 0.
- Address bits at or above log2(DEPTH) are ignored.
- FSM states: IDLE and SPLIT.
  - IDLE: an accepted misaligned word request goes to SPLIT. All other accepted requests stay in IDLE.
  - SPLIT: always returns to IDLE after one cycle.
- SPLIT latches the request fields and the beat-1 read bytes.
- Only one request is in flight at a time, so there is no read/write hazard. A read following a write returns the written data.
- Reset values: state IDLE, RespValid 0, ReadData 0, Error 0.
- Memory contents are not cleared by reset.
- Reset during SPLIT:
  - The beat-1 write stays committed and beat 2 is dropped.
  - No RespValid is produced.
  - ReqReady is high in the first cycle after Reset_n rises.

## Timing
- A request is accepted on the rising edge where ReqValid && ReqReady.
- Byte or aligned word accepted at edge N: RespValid is high in cycle N+1, and the write is visible from N+1. ReqReady stays high, so the block sustains 1 request per cycle.
- Misaligned word accepted at edge N: ReqReady is low in cycle N+1 and RespValid is high in cycle N+2.
- The row RAM reads combinationally. The merged result is registered.
- There is no response backpressure. The consumer must sample ReadData when RespValid is high.

## Configuration
- The macro is DMEM_BOUNDS_CHECK_EN.
- Defined: any access whose last byte address (Address + size − 1) is ≥ DEPTH gets Error = 1 with RespValid, ReadData = 0, and no write to any byte. Latency is unchanged: a misaligned violation still takes 2 cycles.
- Undefined: Error is tied to 0 and addresses and row wrap follow the modulo rules above.

## Structure
- Package dmem_pkg holds:
  - size encodings SIZE_BYTE and SIZE_WORD
  - the FSM state enum (IDLE, SPLIT)
  - a function computing the byte-lane strobes from offset and size
- Sub-module dmem_row_ram: single-port array of DEPTH/BPW rows × DATA_W, with asynchronous read and synchronous write using per-byte strobes.

## Test plan
- Aligned word write 0x1234 at 0x10, then word read 0x10 → ReadData 0x1234 at N+1. Byte reads of 0x10 and 0x11 → 0x0012 and 0x0034.
- Misaligned word write 0xABCD at 0x21 → byte 0x21 = 0xAB and byte 0x22 = 0xCD; ReqReady low in N+1, RespValid in N+2. Word read 0x21 → 0xABCD at N+2.
- Byte write 0x5A at 0x07 with WriteData 0xFF5A → byte 0x06 is unchanged. Word read 0x06 → {old, 0x5A}.
- Word write 0xBEEF at 0x7F, without the macro → byte 0x7F = 0xBE, byte 0x00 = 0xEF. With the macro → Error 1, ReadData 0, memory unchanged.
- Four aligned reads on consecutive cycles → all accepted, with RespValid in four consecutive cycles carrying the correct data.
- Reset_n low during SPLIT of misaligned write 0x1122 at 0x31 → no RespValid; byte 0x31 = 0x11, byte 0x32 keeps its old value; ReqReady high after reset is released.
